fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one syn_fifo write port between NUM_REQ producers. Grants one requester at a time for a burst of up to BURST_MAX beats. Tags each written word with the requester ID and respects FIFO full/near_full backpressure. Sits directly in front of syn_fifo (wr_en/wr_data/full/near_full) in the same clock domain.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Tag width for n requesters, never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority picker starting after last_grant
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last_grant,
    output logic [ID_WIDTH-1:0] o_winner,
    output logic                o_any_valid
);

    // Walk from farthest to nearest so the closest valid requester after last_grant wins
    always_comb begin
        o_winner    = '0;
        o_any_valid = |i_req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[(int'(i_last_grant) + k) % NUM_REQ]) begin
                o_winner = ID_WIDTH'((int'(i_last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one syn_fifo write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wr_data,
    input  logic                           i_fifo_full,
    input  logic                           i_fifo_near_full,
    output logic                           o_grant_active,
    output logic [ID_WIDTH-1:0]            o_grant_id,
    output logic [STALL_CNT_W-1:0]         o_stall_cnt
);

    localparam int BEAT_W = (BURST_MAX <= 1) ? 1 : $clog2(BURST_MAX);

    arb_state_t             r_state;
    logic                   r_grant_active;
    logic [ID_WIDTH-1:0]    r_grant_id;
    logic [ID_WIDTH-1:0]    r_last_grant;
    logic [BEAT_W-1:0]      r_beat_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [ID_WIDTH-1:0]    w_winner;
    logic                   w_any_valid;
    logic                   w_owner_valid;
    logic                   w_owner_last;
    logic                   w_accept;
    logic                   w_burst_done;
    logic [NUM_REQ-1:0]     w_ready;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_valid  (w_any_valid)
    );

    assign w_owner_valid = i_req_valid[r_grant_id];
    assign w_owner_last  = i_req_last[r_grant_id];
    // Reset gates the write so a burst cut by rst leaves no partial beat behind
    assign w_accept      = (r_state == BURST) && w_owner_valid && !i_fifo_full && !i_rst;
    assign w_burst_done  = !w_owner_valid ||
                           (w_accept && (w_owner_last || r_beat_cnt == BEAT_W'(BURST_MAX - 1)));

    always_comb begin
        w_ready             = '0;
        w_ready[r_grant_id] = w_accept;
    end

    assign o_req_ready    = w_ready;
    assign o_fifo_wr_en   = w_accept;
    assign o_fifo_wr_data = {r_grant_id, i_req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH]};
    assign o_grant_active = r_grant_active;
    assign o_grant_id     = r_grant_id;
    assign o_stall_cnt    = r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_grant_active <= 1'b0;
            r_grant_id     <= '0;
            r_last_grant   <= ID_WIDTH'(NUM_REQ - 1);
            r_beat_cnt     <= '0;
            r_stall_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid && !i_fifo_near_full) begin
                        r_state        <= BURST;
                        r_grant_active <= 1'b1;
                        r_grant_id     <= w_winner;
                        r_beat_cnt     <= '0;
                    end
                end
                BURST: begin
                    if (w_owner_valid && i_fifo_full && r_stall_cnt != {STALL_CNT_W{1'b1}}) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                    if (w_burst_done) begin
                        r_state        <= IDLE;
                        r_grant_active <= 1'b0;
                        r_last_grant   <= r_grant_id;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int BM = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            fifo_wr_en;
    logic [IW+DW-1:0] fifo_wr_data;
    logic            fifo_full;
    logic            fifo_near_full;
    logic            grant_active;
    logic [IW-1:0]   grant_id;
    logic [15:0]     stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_data       (req_data),
        .i_req_last       (req_last),
        .o_req_ready      (req_ready),
        .o_fifo_wr_en     (fifo_wr_en),
        .o_fifo_wr_data   (fifo_wr_data),
        .i_fifo_full      (fifo_full),
        .i_fifo_near_full (fifo_near_full),
        .o_grant_active   (grant_active),
        .o_grant_id       (grant_id),
        .o_stall_cnt      (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[k]          = v;
        req_data[k*DW +: DW]  = d;
        req_last[k]           = l;
    endtask

    task automatic expect_write(input string tag, input int id, input logic [DW-1:0] d);
        #1;
        check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd1);
        check({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << id));
        check({tag, "_data"}, 64'(fifo_wr_data), 64'({IW'(id), d}));
    endtask

    task automatic expect_no_write(input string tag);
        #1;
        check({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd0);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        fifo_full = 1'b0;
        fifo_near_full = 1'b0;
        step();
        step();
        expect_no_write("rst_hold");
        check("rst_active", 64'(grant_active), 64'd0);
        check("rst_id", 64'(grant_id), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // Single requester, three beats, last on the third
        set_req(1, 1'b1, 32'hA0, 1'b0);
        expect_no_write("single_idle");
        step();
        check("single_active", 64'(grant_active), 64'd1);
        check("single_id", 64'(grant_id), 64'd1);
        expect_write("single_b0", 1, 32'hA0);
        step();
        set_req(1, 1'b1, 32'hA1, 1'b0);
        expect_write("single_b1", 1, 32'hA1);
        step();
        set_req(1, 1'b1, 32'hA2, 1'b1);
        expect_write("single_b2", 1, 32'hA2);
        step();
        set_req(1, 1'b0, 32'h0, 1'b0);
        check("single_done_active", 64'(grant_active), 64'd0);
        check("single_done_id", 64'(grant_id), 64'd1);
        expect_no_write("single_done");

        // From reset, all four requesters with one-beat bursts: order 0,1,2,3,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 32'h10 + k, 1'b1);
        for (int b = 0; b < 5; b++) begin
            expect_no_write("rr_idle");
            step();
            check("rr_id", 64'(grant_id), 64'(b % NR));
            expect_write("rr_beat", b % NR, 32'h10 + (b % NR));
            step();
        end
        req_valid = '0;
        req_last = '0;

        // Requester 2 without last is cut at BURST_MAX, requester 3 follows
        set_req(2, 1'b1, 32'h20, 1'b0);
        set_req(3, 1'b1, 32'h30, 1'b1);
        step();
        for (int i = 0; i < BM; i++) begin
            set_req(2, 1'b1, 32'h20 + i, 1'b0);
            expect_write("bmax_beat", 2, 32'h20 + i);
            step();
        end
        check("bmax_released", 64'(grant_active), 64'd0);
        expect_no_write("bmax_gap");
        step();
        check("bmax_next_id", 64'(grant_id), 64'd3);
        expect_write("bmax_next", 3, 32'h30);
        step();
        req_valid = '0;
        req_last = '0;

        // Five full cycles mid-burst, then near_full rises without stopping it
        set_req(0, 1'b1, 32'h40, 1'b0);
        step();
        expect_write("full_b0", 0, 32'h40);
        step();
        set_req(0, 1'b1, 32'h41, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_no_write("full_stall");
            step();
        end
        fifo_full = 1'b0;
        check("full_stall_cnt", 64'(stall_cnt), 64'd5);
        expect_write("full_b1", 0, 32'h41);
        step();
        set_req(0, 1'b1, 32'h42, 1'b0);
        fifo_near_full = 1'b1;
        expect_write("nf_mid_b2", 0, 32'h42);
        step();
        set_req(0, 1'b1, 32'h43, 1'b0);
        expect_write("nf_mid_b3", 0, 32'h43);
        step();
        check("full_burst_end", 64'(grant_active), 64'd0);

        // near_full in IDLE blocks a new grant until it drops
        set_req(0, 1'b1, 32'h50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_no_write("nf_idle");
            check("nf_idle_active", 64'(grant_active), 64'd0);
            step();
        end
        fifo_near_full = 1'b0;
        step();
        check("nf_grant_id", 64'(grant_id), 64'd0);
        expect_write("nf_grant", 0, 32'h50);
        step();
        req_valid = '0;
        req_last = '0;

        // Reset during the second beat drops the burst and restores requester 0 priority
        set_req(0, 1'b1, 32'h60, 1'b1);
        set_req(2, 1'b1, 32'h62, 1'b0);
        step();
        check("rstmid_id", 64'(grant_id), 64'd2);
        expect_write("rstmid_b0", 2, 32'h62);
        step();
        rst = 1'b1;
        expect_no_write("rstmid_cycle");
        step();
        rst = 1'b0;
        check("rstmid_active", 64'(grant_active), 64'd0);
        check("rstmid_stall", 64'(stall_cnt), 64'd0);
        expect_no_write("rstmid_idle");
        step();
        check("rstmid_prio_id", 64'(grant_id), 64'd0);
        expect_write("rstmid_prio", 0, 32'h60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
